// File: rtl/parallel_in_serial_out_piso_tx_16_bit.sv
// 16-bit MSB-first PISO transmitter: word accepted on Load_Valid_In & Load_Ready_Out, first bit next cycle, each bit held CLKS_PER_BIT cycles.
// No acceptance while shifting (ready low in SHIFT); Enable_In low freezes everything. Define PISO_TX_PARITY_EN for a trailing even-parity bit.
`timescale 1ns/1ps
module parallel_in_serial_out_piso_tx_16_bit #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic        Clk_In,
   input  logic        Reset_In,
   input  logic        Enable_In,
   input  logic [15:0] Parallel_Data_In,
   input  logic        Load_Valid_In,
   output logic        Load_Ready_Out,
   output logic        Serial_Data_Out,
   output logic        Shift_Data_Signal_Out,
   output logic        Busy_Out,
   output logic        Word_Done_Out
);

   localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] data_q, data_d;
   logic [3:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        sdo_q, sdo_d;
   logic        xfer;
   logic        bit_end;
`ifdef PISO_TX_PARITY_EN
   logic        par_q, par_d;
`endif

   assign bit_end = (cnt_q == CNT_MAX);
   assign xfer    = Load_Valid_In && Load_Ready_Out;

   always_ff @(posedge Clk_In) begin
      if (!Reset_In) begin
         state_q   <= IDLE;
         data_q    <= 16'h0000;
         bit_idx_q <= 4'd0;
         cnt_q     <= 8'd0;
         sdo_q     <= 1'b0;
`ifdef PISO_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else if (Enable_In) begin
         state_q   <= state_d;
         data_q    <= data_d;
         bit_idx_q <= bit_idx_d;
         cnt_q     <= cnt_d;
         sdo_q     <= sdo_d;
`ifdef PISO_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      bit_idx_d = bit_idx_q;
      cnt_d     = cnt_q;
      sdo_d     = sdo_q;
`ifdef PISO_TX_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (xfer) begin
               state_d   = SHIFT;
               data_d    = Parallel_Data_In;
               bit_idx_d = 4'd15;
               cnt_d     = 8'd0;
               sdo_d     = Parallel_Data_In[15];
`ifdef PISO_TX_PARITY_EN
               par_d     = 1'b0;
`endif
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (!bit_end) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               cnt_d = 8'd0;
               // Bit index stops at 0; the final period ends in DONE with the last bit still on the line.
               if (bit_idx_q != 4'd0) begin
                  bit_idx_d = bit_idx_q - 4'd1;
                  sdo_d     = data_q[bit_idx_q - 4'd1];
               end
`ifdef PISO_TX_PARITY_EN
               else if (!par_q) begin
                  par_d = 1'b1;
                  sdo_d = ^data_q;
               end
`endif
               else begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Load_Ready_Out        = ((state_q == IDLE) || (state_q == DONE)) && Enable_In && Reset_In;
      Busy_Out              = (state_q == SHIFT);
      Shift_Data_Signal_Out = (state_q == SHIFT) && bit_end && Enable_In;
      Word_Done_Out         = (state_q == DONE) && Enable_In;
      Serial_Data_Out       = sdo_q;
   end

endmodule

// File: tb/tb_parallel_in_serial_out_piso_tx_16_bit.sv
// Bench: two instances (CLKS_PER_BIT 1 and 4) with a modelled downstream SIPO feeding a word scoreboard.
`timescale 1ns/1ps
module tb_parallel_in_serial_out_piso_tx_16_bit;

`ifdef PISO_TX_PARITY_EN
   localparam int NB = 17;
`else
   localparam int NB = 16;
`endif

   logic        clk = 1'b0;
   logic        rst_n, en;
   logic [15:0] d1, d4;
   logic        v1, v4;
   logic        rdy1, sdo1, stb1, busy1, done1;
   logic        rdy4, sdo4, stb4, busy4, done4;

   int tests = 0;
   int fails = 0;

   logic [15:0] q1[$];
   logic [15:0] q4[$];

   always #5 clk = ~clk;

   parallel_in_serial_out_piso_tx_16_bit #(.CLKS_PER_BIT(1)) dut1 (
      .Clk_In(clk), .Reset_In(rst_n), .Enable_In(en), .Parallel_Data_In(d1),
      .Load_Valid_In(v1), .Load_Ready_Out(rdy1), .Serial_Data_Out(sdo1),
      .Shift_Data_Signal_Out(stb1), .Busy_Out(busy1), .Word_Done_Out(done1));

   parallel_in_serial_out_piso_tx_16_bit #(.CLKS_PER_BIT(4)) dut4 (
      .Clk_In(clk), .Reset_In(rst_n), .Enable_In(en), .Parallel_Data_In(d4),
      .Load_Valid_In(v4), .Load_Ready_Out(rdy4), .Serial_Data_Out(sdo4),
      .Shift_Data_Signal_Out(stb4), .Busy_Out(busy4), .Word_Done_Out(done4));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [15:0] w, input int k);
      if (k < 16) return w[15-k];
      return ^w;
   endfunction

   // Downstream SIPO models: shift on strobe, compare against scoreboard on Word_Done.
   logic [16:0] sh1, sh4;
   int          nb1, nb4;
   logic [15:0] w1, w4;

   always @(negedge clk) begin
      if (!rst_n) begin
         nb1 = 0;
         nb4 = 0;
      end else begin
         if (stb1) begin sh1 = {sh1[15:0], sdo1}; nb1++; end
         if (stb4) begin sh4 = {sh4[15:0], sdo4}; nb4++; end
         if (done1) begin
            if (q1.size() == 0) chk("sb1_underflow", 1, 0);
            else begin
               w1 = q1.pop_front();
               chk("sb1_bits", nb1, NB);
`ifdef PISO_TX_PARITY_EN
               chk("sb1_word", sh1[16:1], w1);
               chk("sb1_parity", sh1[0], ^w1);
`else
               chk("sb1_word", sh1[15:0], w1);
`endif
            end
            nb1 = 0;
         end
         if (done4) begin
            if (q4.size() == 0) chk("sb4_underflow", 1, 0);
            else begin
               w4 = q4.pop_front();
               chk("sb4_bits", nb4, NB);
`ifdef PISO_TX_PARITY_EN
               chk("sb4_word", sh4[16:1], w4);
               chk("sb4_parity", sh4[0], ^w4);
`else
               chk("sb4_word", sh4[15:0], w4);
`endif
            end
            nb4 = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns one cycle after the transfer edge (first bit on the line).
   task automatic send1(input logic [15:0] w);
      int i = 0;
      d1 = w;
      v1 = 1'b1;
      while (!rdy1 && i < 100) begin step(); i++; end
      if (!rdy1) chk("send1_timeout", 0, 1);
      else q1.push_back(w);
      step();
      v1 = 1'b0;
   endtask

   task automatic send4(input logic [15:0] w);
      int i = 0;
      d4 = w;
      v4 = 1'b1;
      while (!rdy4 && i < 200) begin step(); i++; end
      if (!rdy4) chk("send4_timeout", 0, 1);
      else q4.push_back(w);
      step();
      v4 = 1'b0;
   endtask

   task automatic wait_done1(input int start, output int cyc);
      cyc = start;
      while (!done1 && cyc < 300) begin step(); cyc++; end
      if (!done1) chk("done1_timeout", 0, 1);
   endtask

   typedef struct {
      logic [15:0] w;
      int          exp_cyc;
      int          exp_busy;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, cyc, nbusy, nstb, c, nd;
      logic [15:0] w;

      tbl[0] = '{16'h0000, NB + 1, NB};
      tbl[1] = '{16'hFFFF, NB + 1, NB};
      tbl[2] = '{16'h8001, NB + 1, NB};
      tbl[3] = '{16'h0001, NB + 1, NB};
      tbl[4] = '{16'h5555, NB + 1, NB};
      tbl[5] = '{16'hAAAA, NB + 1, NB};

      // Reset with enable and valid both asserted
      rst_n = 1'b0; en = 1'b1; v1 = 1'b1; d1 = 16'hBEEF; v4 = 1'b1; d4 = 16'hBEEF;
      sh1 = '0; sh4 = '0; nb1 = 0; nb4 = 0;
      step();
      chk("reset_ready_low", {rdy1, rdy4}, 2'b00);
      step();
      chk("reset_outs1", {busy1, sdo1, stb1, done1, rdy1}, 5'b0);
      chk("reset_outs4", {busy4, sdo4, stb4, done4, rdy4}, 5'b0);
      v1 = 1'b0; v4 = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("ready_after_reset", {rdy1, rdy4}, 2'b11);
      step();
      chk("no_xfer_in_reset", {busy1, busy4}, 2'b00);

      // 0xA5C3 stream, cycle-by-cycle
      w = 16'hA5C3;
      send1(w);
      bad = 0;
      for (int k = 0; k < NB; k++) begin
         if (sdo1 !== exp_bit(w, k) || stb1 !== 1'b1 || busy1 !== 1'b1 || done1 !== 1'b0) bad++;
         step();
      end
      chk("a5c3_stream", bad, 0);
      chk("a5c3_done", {done1, busy1, sdo1}, {1'b1, 1'b0, exp_bit(w, NB - 1)});
      step();
      chk("a5c3_idle", {done1, busy1, rdy1}, 3'b001);

      // Table of words
      for (int i = 0; i < 6; i++) begin
         send1(tbl[i].w);
         cyc = 1; nbusy = 0;
         while (!done1 && cyc < 300) begin
            if (busy1) nbusy++;
            step();
            cyc++;
         end
         chk("tbl_done_cyc", cyc, tbl[i].exp_cyc);
         chk("tbl_busy", nbusy, tbl[i].exp_busy);
         step();
      end

      // CLKS_PER_BIT=4 with 0x8001
      w = 16'h8001;
      send4(w);
      c = 0; bad = 0; nbusy = 0; nstb = 0;
      while (!done4 && c < 400) begin
         if (busy4) begin
            nbusy++;
            if (sdo4 !== exp_bit(w, c / 4)) bad++;
            if (stb4 !== ((c % 4) == 3)) bad++;
            if (stb4) nstb++;
         end
         step();
         c++;
      end
      chk("cpb4_hold", bad, 0);
      chk("cpb4_busy", nbusy, 4 * NB);
      chk("cpb4_strobes", nstb, NB);
      chk("cpb4_done_sdo", sdo4, exp_bit(w, NB - 1));
      step();

      // Enable dropped for 5 cycles during bit 4 of 0x1234
      w = 16'h1234;
      send1(w);
      repeat (4) step();
      en = 1'b0;
      #1;
      bad = 0;
      for (int j = 0; j < 5; j++) begin
         if (stb1 !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b1 || sdo1 !== exp_bit(w, 4)) bad++;
         step();
      end
      chk("freeze_outputs", bad, 0);
      en = 1'b1;
      #1;
      chk("freeze_resume", {stb1, sdo1}, {1'b1, exp_bit(w, 4)});
      wait_done1(10, cyc);
      chk("freeze_latency", cyc, NB + 1 + 5);
      step();

      // Back-to-back: 0xFFFF then 0x0000 offered during SHIFT, accepted in DONE
      send1(16'hFFFF);
      d1 = 16'h0000;
      v1 = 1'b1;
      c = 1; bad = 0;
      while (!rdy1 && c < 300) begin
         if (busy1 !== 1'b1) bad++;
         step();
         c++;
      end
      chk("shift_blocks_ready", bad, 0);
      chk("ready_first_in_done", c, NB + 1);
      chk("done_with_ready", done1, 1'b1);
      q1.push_back(16'h0000);
      step();
      v1 = 1'b0;
      chk("b2b_start", {busy1, sdo1, done1}, 3'b100);
      wait_done1(1, cyc);
      chk("b2b_done", cyc, NB + 1);
      step();

      // Reset during bit 8 aborts the word
      send1(16'hA5C3);
      repeat (8) step();
      chk("pre_abort_sdo", sdo1, exp_bit(16'hA5C3, 8));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      q1.delete();
      #1;
      chk("abort_outs", {busy1, stb1, done1, sdo1, rdy1}, 5'b00001);
      nd = 0;
      repeat (40) begin
         if (done1) nd++;
         step();
      end
      chk("abort_no_done", nd, 0);
      send1(16'h0F0F);
      wait_done1(1, cyc);
      chk("recover_done", cyc, NB + 1);
      step();
      step();

      chk("q1_empty", q1.size(), 0);
      chk("q4_empty", q4.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
